// File: rtl/regfile.sv
// 8 x 16-bit register file: one synchronous write port, one combinational read port.
// Optional REGFILE_WRITE_BYPASS_EN forwards data_in to data_out when writing the register being read.
module regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] writenum,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] readnum,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   write_sel_s;
    logic [DATA_WIDTH-1:0] read_data_s;

    // One-hot decode of the write index, gated by the write enable.
    always_comb begin
        write_sel_s = {NUM_REGS{1'b0}};
        if (write) begin
            write_sel_s = NUM_REGS'(1) << writenum;
        end else begin
            write_sel_s = {NUM_REGS{1'b0}};
        end
    end

    // Register storage; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!reset_n) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end else if (write_sel_s[i]) begin
                regs_r[i] <= data_in;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Read mux with write-through forwarding of the value about to be written.
    always_comb begin
        read_data_s = regs_r[readnum];
        if (write && reset_n && (writenum == readnum)) begin
            read_data_s = data_in;
        end else begin
            read_data_s = regs_r[readnum];
        end
    end
`else
    // Read mux: stored contents only, new values appear after the writing edge.
    always_comb begin
        read_data_s = regs_r[readnum];
    end
`endif

    assign data_out = read_data_s;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expected read values flow through a scoreboard queue.
module tb_regfile;

    logic        clk;
    logic        reset_n;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];
    string       tag_q [$];
    logic [15:0] mdl [8];

    regfile dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .writenum (writenum),
        .write    (write),
        .readnum  (readnum),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_next();
        logic [15:0] exp_v;
        string       tag_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <queued value>", data_out);
        end else begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            assert (data_out === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag_v, data_out, exp_v);
            end
        end
    endtask

    task automatic expect_read(input logic [2:0] idx, input logic [15:0] exp_v, input string tag);
        readnum = idx;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        #1;
        compare_next();
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
        write    = 1'b1;
        writenum = idx;
        data_in  = val;
        tick();
        write    = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        write    = 1'b0;
        writenum = 3'd0;
        readnum  = 3'd0;
        data_in  = 16'h0000;

        // Reset clears every register.
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) expect_read(3'(i), 16'h0000, $sformatf("reset_r%0d", i));

        // Write and read back R0, then overwrite.
        do_write(3'd0, 16'h0001);
        expect_read(3'd0, 16'h0001, "r0_first");
        write    = 1'b1;
        writenum = 3'd0;
        data_in  = 16'hFFFF;
        readnum  = 3'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_read(3'd0, 16'hFFFF, "r0_pre_edge_bypass");
`else
        expect_read(3'd0, 16'h0001, "r0_pre_edge_old");
`endif
        tick();
        write = 1'b0;
        expect_read(3'd0, 16'hFFFF, "r0_overwrite");

        // Isolation: writing other registers leaves R0 alone.
        do_write(3'd0, 16'h0001);
        do_write(3'd1, 16'h0006);
        expect_read(3'd0, 16'h0001, "r0_after_r1");
        expect_read(3'd1, 16'h0006, "r1_value");
        do_write(3'd3, 16'hFFFE);
        do_write(3'd4, 16'hFFFC);
        do_write(3'd5, 16'hFFF8);
        do_write(3'd6, 16'hFFF0);
        do_write(3'd7, 16'hFFE0);
        expect_read(3'd3, 16'hFFFE, "r3_value");
        expect_read(3'd4, 16'hFFFC, "r4_value");
        expect_read(3'd5, 16'hFFF8, "r5_value");
        expect_read(3'd6, 16'hFFF0, "r6_value");
        expect_read(3'd7, 16'hFFE0, "r7_value");

        // Write disabled: nothing changes.
        write    = 1'b0;
        writenum = 3'd2;
        data_in  = 16'hFFFF;
        tick();
        expect_read(3'd1, 16'h0006, "wdis_r1");
        expect_read(3'd2, 16'h0000, "wdis_r2");

        // Cross-write: reading R7 while writing R2.
        readnum = 3'd7;
        do_write(3'd2, 16'hFFFF);
        expect_read(3'd7, 16'hFFE0, "cross_r7");
        expect_read(3'd2, 16'hFFFF, "cross_r2");

        // Reset has priority over a same-cycle write.
        reset_n  = 1'b0;
        write    = 1'b1;
        writenum = 3'd5;
        data_in  = 16'h1234;
        tick();
        reset_n = 1'b1;
        write   = 1'b0;
        expect_read(3'd5, 16'h0000, "rst_prio_r5");
        expect_read(3'd2, 16'h0000, "rst_prio_r2");

        // Same-index write/read around the edge.
        do_write(3'd3, 16'h1111);
        write    = 1'b1;
        writenum = 3'd3;
        data_in  = 16'hA5A5;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_read(3'd3, 16'hA5A5, "same_idx_bypass");
`else
        expect_read(3'd3, 16'h1111, "same_idx_old");
`endif
        tick();
        write = 1'b0;
        expect_read(3'd3, 16'hA5A5, "same_idx_after");

        // Randomised writes against a bench-side register model.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        for (int k = 0; k < 24; k++) begin
            logic [2:0]  a;
            logic [15:0] d;
            logic        we;
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            write    = we;
            writenum = a;
            data_in  = d;
            tick();
            write = 1'b0;
            if (we) mdl[a] = d;
            a = 3'($urandom_range(0, 7));
            expect_read(a, mdl[a], $sformatf("rand_%0d_r%0d", k, a));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
